branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit_pkg.sv | 24 ++
 rtl/sat_counter.sv | 28 ++
 rtl/branch_predict_unit.sv | 171 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared constants and types for the branch prediction unit
package branch_predict_unit_pkg;

  // PC layout: word-aligned instructions, low two bits never index the BTB
  localparam int unsigned PC_ALIGN_BITS      = 2;
  // Sequential instruction step (used when a non-branch was mispredicted as taken)
  localparam int unsigned INSN_BYTES         = 4;
  // Not-taken fall-through skips the branch and its delay slot
  localparam int unsigned FALLTHROUGH_OFFSET = 8;

  // Kind of BTB write produced by one resolution
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_HIT,
    UPD_ALLOC,
    UPD_INVAL
  } upd_kind_e;

  // Width of the stored tag for a given PC width and index width
  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned idx_w);
    return addr_w - idx_w - PC_ALIGN_BITS;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down counter with load
module sat_counter #(
  parameter int unsigned       WIDTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  // Load wins; otherwise step one way, holding at all-ones or zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !dec && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB predictor with misprediction redirect
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  res_valid,
  input  logic [ADDR_WIDTH-1:0] res_pc,
  input  logic                  res_is_branch,
  input  logic                  res_taken,
  input  logic [ADDR_WIDTH-1:0] res_target,
  input  logic                  res_pred_taken,
  input  logic [ADDR_WIDTH-1:0] res_pred_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = tag_width(ADDR_WIDTH, IDX_W);
  localparam int unsigned IDX_LO = PC_ALIGN_BITS;
  localparam int unsigned TAG_LO = IDX_W + PC_ALIGN_BITS;

  localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_T  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0]  CTR_WEAK_NT = CTR_WIDTH'(CTR_WEAK_T - 1'b1);
  localparam logic [ADDR_WIDTH-1:0] OFF_SEQ     = ADDR_WIDTH'(INSN_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_FALL    = ADDR_WIDTH'(FALLTHROUGH_OFFSET);

  logic [ENTRIES-1:0]    valid;
  logic [TAG_W-1:0]      tag_mem [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_mem [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr     [ENTRIES];

  logic [IDX_W-1:0]      if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;
  logic [IDX_W-1:0]      res_idx;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_hit;
  upd_kind_e             upd_kind;
  logic                  alias_mis;
  logic                  dir_mis;
  logic                  mis;
  logic [ADDR_WIDTH-1:0] correct_pc;
  logic                  unused_low_bits;

  assign if_idx  = if_pc[TAG_LO-1:IDX_LO];
  assign if_tag  = if_pc[ADDR_WIDTH-1:TAG_LO];
  assign res_idx = res_pc[TAG_LO-1:IDX_LO];
  assign res_tag = res_pc[ADDR_WIDTH-1:TAG_LO];

  // Instruction alignment bits carry no prediction information
  assign unused_low_bits = ^{if_pc[IDX_LO-1:0], res_pc[IDX_LO-1:0]};

  // Lookup reads the registered table, so same-cycle updates are not yet visible
  always_comb begin
    if_hit      = valid[if_idx] && (tag_mem[if_idx] == if_tag);
    pred_taken  = if_hit && ctr[if_idx][CTR_WIDTH-1];
    pred_target = pred_taken ? tgt_mem[if_idx] : '0;
  end

  // Classify the table write implied by this resolution
  always_comb begin
    res_hit  = valid[res_idx] && (tag_mem[res_idx] == res_tag);
    upd_kind = UPD_NONE;
    if (res_valid) begin
      if (res_is_branch) begin
        if (res_hit)        upd_kind = UPD_HIT;
        else if (res_taken) upd_kind = UPD_ALLOC;
      end else if (res_hit) begin
        upd_kind = UPD_INVAL;
      end
    end
  end

  // Misprediction detection and the address fetch should have gone to
  always_comb begin
    alias_mis  = !res_is_branch && res_pred_taken;
    dir_mis    = (res_taken != res_pred_taken) ||
                 (res_taken && (res_target != res_pred_target));
    mis        = res_valid && (alias_mis || dir_mis);
    correct_pc = alias_mis ? (res_pc + OFF_SEQ)
                           : (res_taken ? res_target : (res_pc + OFF_FALL));
  end

  // One-cycle redirect pulse; reset drops any pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict  <= mis;
      redirect_pc <= mis ? correct_pc : '0;
    end
  end

  // Entry valid bits: set on allocation, cleared when a non-branch aliases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (upd_kind == UPD_ALLOC) begin
      valid[res_idx] <= 1'b1;
    end else if (upd_kind == UPD_INVAL) begin
      valid[res_idx] <= 1'b0;
    end
  end

  // Tag and target storage; meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (upd_kind == UPD_ALLOC) begin
      tag_mem[res_idx] <= res_tag;
      tgt_mem[res_idx] <= res_target;
    end else if ((upd_kind == UPD_HIT) && res_taken) begin
      tgt_mem[res_idx] <= res_target;
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = (res_idx == IDX_W'(e));

    sat_counter #(
      .WIDTH   (CTR_WIDTH),
      .RST_VAL (CTR_WEAK_NT)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (sel && (upd_kind == UPD_HIT) && res_taken),
      .dec      (sel && (upd_kind == UPD_HIT) && !res_taken),
      .load     (sel && (upd_kind == UPD_ALLOC)),
      .load_val (CTR_WEAK_T),
      .count    (ctr[e])
    );
  end

  sat_counter #(
    .WIDTH   (PERF_WIDTH),
    .RST_VAL ('0)
  ) u_perf_branches (
    .clk      (clk),
    .rst      (rst),
    .inc      (res_valid && res_is_branch),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (perf_branches)
  );

  sat_counter #(
    .WIDTH   (PERF_WIDTH),
    .RST_VAL ('0)
  ) u_perf_mispredicts (
    .clk      (clk),
    .rst      (rst),
    .inc      (mis),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .count    (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  perf_branches;
  logic [3:0]  perf_mispredicts;

  int errors = 0;
  int checks = 0;

  branch_predict_unit #(
    .ENTRIES    (16),
    .ADDR_WIDTH (32),
    .CTR_WIDTH  (2),
    .PERF_WIDTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_is_branch    (res_is_branch),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_pred_taken   (res_pred_taken),
    .res_pred_target  (res_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic res_set(input logic v, input logic [31:0] pc, input logic isb, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    res_valid       = v;
    res_pc          = pc;
    res_is_branch   = isb;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  task automatic res_idle();
    res_set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    if_pc = 32'h0040_0000;
    res_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("reset_pred_target", pred_target, 32'h0);
    check("reset_perf_branches", {28'b0, perf_branches}, 32'h0);
    check("reset_perf_mispredicts", {28'b0, perf_mispredicts}, 32'h0);
    check("reset_mispredict", {31'b0, mispredict}, 32'h0);

    // Taken branch, predicted not taken: allocate and redirect to target
    res_set(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    step();
    check("alloc_mispredict", {31'b0, mispredict}, 32'h1);
    check("alloc_redirect", redirect_pc, 32'h0040_0100);
    res_idle();
    if_pc = 32'h0040_0010;
    #1;
    check("alloc_pred_taken", {31'b0, pred_taken}, 32'h1);
    check("alloc_pred_target", pred_target, 32'h0040_0100);
    check("alloc_perf_branches", {28'b0, perf_branches}, 32'h1);
    check("alloc_perf_mis", {28'b0, perf_mispredicts}, 32'h1);
    step();
    check("pulse_one_cycle", {31'b0, mispredict}, 32'h0);

    // Two not-taken resolutions: counter 2 -> 1 -> 0
    res_set(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    step();
    check("nt1_mispredict", {31'b0, mispredict}, 32'h1);
    check("nt1_redirect_fallthrough", redirect_pc, 32'h0040_0018);
    check("nt1_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("nt1_pred_target", pred_target, 32'h0);
    res_set(1'b1, 32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    check("nt2_no_mispredict", {31'b0, mispredict}, 32'h0);
    check("nt2_pred_taken", {31'b0, pred_taken}, 32'h0);

    // Counter reached 0: one taken brings it to 1 (still not taken), a second to 2
    res_set(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    step();
    check("ctr1_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("ctr1_mispredict", {31'b0, mispredict}, 32'h1);
    step();
    check("ctr2_pred_taken", {31'b0, pred_taken}, 32'h1);
    check("ctr2_perf_branches", {28'b0, perf_branches}, 32'h5);
    check("ctr2_perf_mis", {28'b0, perf_mispredicts}, 32'h4);

    // Non-branch aliasing a taken entry: redirect to pc+4, entry invalidated
    res_set(1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    step();
    check("alias_mispredict", {31'b0, mispredict}, 32'h1);
    check("alias_redirect", redirect_pc, 32'h0040_0014);
    check("alias_invalidated", {31'b0, pred_taken}, 32'h0);
    check("alias_perf_branches", {28'b0, perf_branches}, 32'h5);
    check("alias_perf_mis", {28'b0, perf_mispredicts}, 32'h5);

    // Same-cycle lookup and allocate on index 8: old contents seen first
    if_pc = 32'h0040_0020;
    res_set(1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    #1;
    check("samecyc_old_pred", {31'b0, pred_taken}, 32'h0);
    step();
    res_idle();
    #1;
    check("samecyc_new_pred", {31'b0, pred_taken}, 32'h1);
    check("samecyc_new_target", pred_target, 32'h0040_0200);
    check("samecyc_redirect", redirect_pc, 32'h0040_0200);
    if_pc = 32'h0050_0020;
    #1;
    check("tag_mismatch_pred", {31'b0, pred_taken}, 32'h0);

    // Correct prediction gives no pulse; wrong target does
    res_set(1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
    step();
    check("correct_no_mispredict", {31'b0, mispredict}, 32'h0);
    res_set(1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0204);
    step();
    check("target_mis_mispredict", {31'b0, mispredict}, 32'h1);
    check("target_mis_redirect", redirect_pc, 32'h0040_0200);
    check("target_mis_perf_branches", {28'b0, perf_branches}, 32'h8);
    check("target_mis_perf_mis", {28'b0, perf_mispredicts}, 32'h7);

    // Reset mid-stream with a redirect pending
    res_set(1'b1, 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    step();
    check("pre_rst_mispredict", {31'b0, mispredict}, 32'h1);
    rst   = 1'b1;
    if_pc = 32'h0040_0020;
    #1;
    check("rst_mispredict", {31'b0, mispredict}, 32'h0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("rst_pred_target", pred_target, 32'h0);
    check("rst_perf_branches", {28'b0, perf_branches}, 32'h0);
    check("rst_perf_mis", {28'b0, perf_mispredicts}, 32'h0);
    step();
    rst = 1'b0;
    res_idle();
    step();
    check("post_rst_no_pulse", {31'b0, mispredict}, 32'h0);

    // 20 back-to-back mispredictions: pulses every cycle, counters saturate at 15
    res_set(1'b1, 32'h0040_0040, 1'b1, 1'b1, 32'h0040_0400, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("b2b_pulse_%0d", i), {31'b0, mispredict}, 32'h1);
    end
    res_idle();
    check("sat_perf_mis", {28'b0, perf_mispredicts}, 32'hF);
    check("sat_perf_branches", {28'b0, perf_branches}, 32'hF);
    step();
    check("b2b_end_no_pulse", {31'b0, mispredict}, 32'h0);
    check("sat_perf_mis_hold", {28'b0, perf_mispredicts}, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
